// File: rtl/sram_pixel_arbiter_if.sv
// sram_pixel_arbiter_if: display/painter request ports plus the 16-bit SRAM bus.
// Signal names are seen from the arbiter: i_* are arbiter inputs, o_* are arbiter outputs.
// slave = the arbiter, master = whatever drives requests and models the SRAM.
interface sram_pixel_arbiter_if;
  logic        i_disp_req;
  logic [18:0] i_disp_addr;
  logic        o_disp_gnt;
  logic        o_disp_valid;
  logic [23:0] o_disp_rgb;
  logic        i_pnt_req;
  logic        i_pnt_we;
  logic [18:0] i_pnt_addr;
  logic [23:0] i_pnt_wdata;
  logic        o_pnt_gnt;
  logic        o_pnt_valid;
  logic [23:0] o_pnt_rgb;
  logic [19:0] o_sram_addr;
  logic        o_sram_ce_n;
  logic        o_sram_oe_n;
  logic        o_sram_we_n;
  logic [15:0] o_sram_dq;
  logic        o_sram_dq_oe;
  logic [15:0] i_sram_dq;
  modport slave (
    input  i_disp_req, i_disp_addr, i_pnt_req, i_pnt_we, i_pnt_addr, i_pnt_wdata, i_sram_dq,
    output o_disp_gnt, o_disp_valid, o_disp_rgb, o_pnt_gnt, o_pnt_valid, o_pnt_rgb,
           o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_dq, o_sram_dq_oe
  );
  modport master (
    output i_disp_req, i_disp_addr, i_pnt_req, i_pnt_we, i_pnt_addr, i_pnt_wdata, i_sram_dq,
    input  o_disp_gnt, o_disp_valid, o_disp_rgb, o_pnt_gnt, o_pnt_valid, o_pnt_rgb,
           o_sram_addr, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_dq, o_sram_dq_oe
  );
endinterface

// File: rtl/sram_pixel_arbiter.sv
// sram_pixel_arbiter: arbitrates display reads and painter reads/writes onto a 16-bit async SRAM.
// Ports: i_clk, i_rst_n (async active-low), bus (sram_pixel_arbiter_if.slave) carrying both
// requester ports and the SRAM bus. A pixel is two words: HI at {idx,0}, LO at {idx,1}.
module sram_pixel_arbiter #(
  parameter int MAX_PIX    = 307200,
  parameter int STARVE_LIM = 4
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  sram_pixel_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, DONE} state_t;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_pnt, r_we, r_ok;
  logic [18:0] r_addr;
  logic [23:0] r_wdata;
  logic [12:0] r_hi;
  logic        r_disp_gnt, r_disp_valid, r_pnt_gnt, r_pnt_valid;
  logic [23:0] r_disp_rgb, r_pnt_rgb;
  logic [19:0] r_sram_addr;
  logic [15:0] r_sram_dq;
  logic        r_ce_n, r_oe_n, r_we_n, r_dq_oe;
  logic        w_any, w_pnt_win, w_we, w_ok, w_unused;
  logic [18:0] w_addr;
  logic [23:0] w_rgb;
  assign w_any     = bus.i_disp_req | bus.i_pnt_req;
  // The painter takes the slot when the display is idle or has used up its starvation budget.
  assign w_pnt_win = bus.i_pnt_req & (~bus.i_disp_req | (r_cnt == 3'(STARVE_LIM)));
  assign w_we      = w_pnt_win & bus.i_pnt_we;
  assign w_addr    = w_pnt_win ? bus.i_pnt_addr : bus.i_disp_addr;
  assign w_ok      = {13'd0, w_addr} < 32'(MAX_PIX);
  // r_hi keeps only the HI bits that carry colour: {HI[14:10], HI[9:2]}.
  assign w_rgb     = r_ok ? {r_hi[7:0], r_hi[12:8], bus.i_sram_dq[14:12], bus.i_sram_dq[9:2]} : 24'h0;
  assign w_unused  = ^{bus.i_sram_dq[15], bus.i_sram_dq[11:10], bus.i_sram_dq[1:0]};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pnt        <= 1'b0;
      r_we         <= 1'b0;
      r_ok         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hi         <= '0;
      r_disp_gnt   <= 1'b0;
      r_disp_valid <= 1'b0;
      r_pnt_gnt    <= 1'b0;
      r_pnt_valid  <= 1'b0;
      r_disp_rgb   <= '0;
      r_pnt_rgb    <= '0;
      r_sram_addr  <= '0;
      r_sram_dq    <= '0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_dq_oe      <= 1'b0;
    end else begin
      r_disp_gnt   <= 1'b0;
      r_pnt_gnt    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_pnt_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= (!bus.i_pnt_req || w_pnt_win) ? 3'd0 :
                   (r_cnt < 3'(STARVE_LIM)) ? r_cnt + 3'd1 : r_cnt;
          if (w_any) begin
            r_state     <= ACC_HI;
            r_pnt       <= w_pnt_win;
            r_we        <= w_we;
            r_ok        <= w_ok;
            r_addr      <= w_addr;
            r_wdata     <= bus.i_pnt_wdata;
            r_disp_gnt  <= ~w_pnt_win;
            r_pnt_gnt   <= w_pnt_win;
            r_sram_addr <= {w_addr, 1'b0};
            r_ce_n      <= ~w_ok;
            r_oe_n      <= w_we;
            r_we_n      <= ~w_we;
            r_dq_oe     <= w_we;
            r_sram_dq   <= {1'b0, bus.i_pnt_wdata[15:11], bus.i_pnt_wdata[23:16], 2'b00};
          end
        end
        ACC_HI: begin
          r_state     <= ACC_LO;
          r_hi        <= {bus.i_sram_dq[14:10], bus.i_sram_dq[9:2]};
          r_sram_addr <= {r_addr, 1'b1};
          r_sram_dq   <= {1'b0, r_wdata[10:8], 2'b00, r_wdata[7:0], 2'b00};
        end
        ACC_LO: begin
          r_state      <= DONE;
          r_ce_n       <= 1'b1;
          r_oe_n       <= 1'b1;
          r_we_n       <= 1'b1;
          r_dq_oe      <= 1'b0;
          r_disp_valid <= ~r_pnt & ~r_we;
          r_pnt_valid  <= r_pnt & ~r_we;
          r_disp_rgb   <= (!r_pnt && !r_we) ? w_rgb : r_disp_rgb;
          r_pnt_rgb    <= (r_pnt && !r_we) ? w_rgb : r_pnt_rgb;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.o_disp_gnt   = r_disp_gnt;
  assign bus.o_disp_valid = r_disp_valid;
  assign bus.o_disp_rgb   = r_disp_rgb;
  assign bus.o_pnt_gnt    = r_pnt_gnt;
  assign bus.o_pnt_valid  = r_pnt_valid;
  assign bus.o_pnt_rgb    = r_pnt_rgb;
  assign bus.o_sram_addr  = r_sram_addr;
  assign bus.o_sram_ce_n  = r_ce_n;
  assign bus.o_sram_oe_n  = r_oe_n;
  assign bus.o_sram_we_n  = r_we_n;
  assign bus.o_sram_dq    = r_sram_dq;
  assign bus.o_sram_dq_oe = r_dq_oe;
endmodule
